// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decoded-instruction, operand and writeback handshakes of the
// operand fetch stage. The fetch block uses the slave modport; its neighbours use master.
interface operand_fetch_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_src_a;
  logic [2:0]  in_src_b;
  logic [2:0]  in_dst;
  logic        in_dst_we;

  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_op_a;
  logic [15:0] out_op_b;
  logic [2:0]  out_dst;
  logic        out_dst_we;

  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;

  modport slave (
    input  in_valid, in_src_a, in_src_b, in_dst, in_dst_we,
    output in_ready,
    output out_valid, out_op_a, out_op_b, out_dst, out_dst_we,
    input  out_ready,
    input  wb_valid, wb_reg, wb_data,
    output wb_ready
  );

  modport master (
    output in_valid, in_src_a, in_src_b, in_dst, in_dst_we,
    input  in_ready,
    input  out_valid, out_op_a, out_op_b, out_dst, out_dst_we,
    output out_ready,
    output wb_valid, wb_reg, wb_data,
    input  wb_ready
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: reads two operands from a bidirectional register file, tracks
// pending destinations (RAW/WAW stall) and performs writebacks. Option: FETCH_ZERO_R0_EN.
module operand_fetch (
  input  logic           clk0,
  input  logic           reset_n,
  operand_fetch_if.slave ifc,
  output logic [2:0]     a,
  output logic           a_read,
  inout  wire  [15:0]    a_data,
  output logic [2:0]     b,
  output logic           b_read,
  inout  wire  [15:0]    b_data
);
  typedef enum logic [1:0] {IDLE, READ, HOLD, WRITE} state_t;

  state_t      state, state_d;
  logic        ret_hold, ret_hold_d;
  logic [7:0]  pending;
  logic [2:0]  src_a_q, src_b_q, dst_q;
  logic        dst_we_q;
  logic [2:0]  wb_reg_q;
  logic [15:0] wb_data_q;
  logic [15:0] op_a_q, op_b_q;
  logic [2:0]  out_dst_q;
  logic        out_dst_we_q;

  logic        wb_ready_w, in_ready_w, out_valid_w;
  logic        wb_accept, wb_skip, in_accept, out_fire, a_drive, set_pend;
  logic [15:0] rd_a, rd_b;

`ifdef FETCH_ZERO_R0_EN
  // r0 is hardwired: its writebacks are acknowledged but never reach the file.
  assign wb_skip  = (ifc.wb_reg == 3'd0);
  assign rd_a     = (src_a_q == 3'd0) ? 16'h0000 : a_data;
  assign rd_b     = (src_b_q == 3'd0) ? 16'h0000 : b_data;
  assign set_pend = dst_we_q && (dst_q != 3'd0);
`else
  assign wb_skip  = 1'b0;
  assign rd_a     = a_data;
  assign rd_b     = b_data;
  assign set_pend = dst_we_q;
`endif

  assign wb_ready_w  = (state == IDLE) || (state == HOLD);
  assign out_valid_w = (state == HOLD);
  // Writeback has priority: an instruction is never taken while wb_valid is high.
  assign in_ready_w  = (state == IDLE) && !ifc.wb_valid && !pending[ifc.in_src_a]
                     && !pending[ifc.in_src_b] && !pending[ifc.in_dst];
  assign wb_accept   = ifc.wb_valid && wb_ready_w;
  assign in_accept   = ifc.in_valid && in_ready_w;
  assign out_fire    = out_valid_w && ifc.out_ready;

  assign ifc.wb_ready   = wb_ready_w;
  assign ifc.in_ready   = in_ready_w;
  assign ifc.out_valid  = out_valid_w;
  assign ifc.out_op_a   = op_a_q;
  assign ifc.out_op_b   = op_b_q;
  assign ifc.out_dst    = out_dst_q;
  assign ifc.out_dst_we = out_dst_we_q;

  // The block only ever drives bus a, and only in WRITE where a_read is 0.
  assign a_data = a_drive ? wb_data_q : 16'bz;
  assign b_data = 16'bz;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case leaves a signal unassigned and a latch is never inferred.
  always_comb begin
    state_d    = state;
    ret_hold_d = ret_hold;
    a          = 3'd0;
    b          = 3'd0;
    a_read     = 1'b1;
    b_read     = 1'b1;
    a_drive    = 1'b0;
    case (state)
      IDLE: begin
        if (wb_accept && !wb_skip) begin
          state_d    = WRITE;
          ret_hold_d = 1'b0;
        end else if (in_accept) begin
          state_d = READ;
        end
      end
      READ: begin
        a       = src_a_q;
        b       = src_b_q;
        state_d = HOLD;
      end
      HOLD: begin
        if (wb_accept && !wb_skip) begin
          state_d    = WRITE;
          ret_hold_d = !out_fire;
        end else if (out_fire) begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        a       = wb_reg_q;
        a_read  = 1'b0;
        a_drive = 1'b1;
        state_d = ret_hold ? HOLD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ret_hold     <= 1'b0;
      pending      <= 8'h00;
      src_a_q      <= 3'd0;
      src_b_q      <= 3'd0;
      dst_q        <= 3'd0;
      dst_we_q     <= 1'b0;
      wb_reg_q     <= 3'd0;
      wb_data_q    <= 16'h0000;
      op_a_q       <= 16'h0000;
      op_b_q       <= 16'h0000;
      out_dst_q    <= 3'd0;
      out_dst_we_q <= 1'b0;
    end else begin
      state    <= state_d;
      ret_hold <= ret_hold_d;
      if (in_accept) begin
        src_a_q  <= ifc.in_src_a;
        src_b_q  <= ifc.in_src_b;
        dst_q    <= ifc.in_dst;
        dst_we_q <= ifc.in_dst_we;
      end
      if (wb_accept) begin
        wb_reg_q  <= ifc.wb_reg;
        wb_data_q <= ifc.wb_data;
      end
      if (state == READ) begin
        op_a_q       <= rd_a;
        op_b_q       <= rd_b;
        out_dst_q    <= dst_q;
        out_dst_we_q <= dst_we_q;
        if (set_pend) pending[dst_q] <= 1'b1;
      end
      if (state == WRITE) pending[wb_reg_q] <= 1'b0;
    end
  end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL use one clock and asynchronous active-low reset; ports: clk0 in 1, clock (all state on rising edge); reset_n in 1, async active-low reset.
REQ-002 in_valid in 1; in_ready out 1; in_src_a in 3; in_src_b in 3; in_dst in 3; in_dst_we in 1: decoded-instruction handshake.
REQ-003 a out 3; a_read out 1; a_data inout 16; b out 3; b_read out 1; b_data inout 16: register-file ports (read=1 file drives bus; read=0 block drives bus, file writes on clk0 edge).
REQ-004 out_valid out 1; out_ready in 1; out_op_a out 16; out_op_b out 16; out_dst out 3; out_dst_we out 1: operand handshake to execute stage.
REQ-005 wb_valid in 1; wb_ready out 1; wb_reg in 3; wb_data in 16: writeback request from execute stage.

Function
REQ-006 The block SHALL implement states IDLE, READ, HOLD, WRITE plus a 1-bit return flag (ret_hold) for WRITE.
REQ-007 The block SHALL keep an 8-bit pending scoreboard, one bit per register.
REQ-008 wb_ready SHALL be 1 in IDLE and HOLD, else 0; accept = wb_valid&wb_ready latches wb_reg/wb_data, enters WRITE; ret_hold = 1 if in HOLD and not leaving HOLD this edge.
REQ-009 in_ready SHALL be 1 only in IDLE with wb_valid=0 and pending[in_src_a], pending[in_src_b], pending[in_dst] all 0 (RAW and WAW stall); writeback wins simultaneous arrival.
REQ-010 Instruction accept SHALL latch src/dst/we and enter READ.
REQ-011 In READ: a=src_a, b=src_b, a_read=b_read=1, block tri-states both buses; at the edge closing READ: out_op_a<=a_data, out_op_b<=b_data, pending[dst] set if dst_we, -> HOLD (fetch latency 2 edges from accept to out_valid).
REQ-012 out_valid SHALL be 1 only in HOLD; out_valid&out_ready -> IDLE, or WRITE (ret_hold=0) if a writeback is accepted the same edge.
REQ-013 In WRITE: a=latched wb_reg, a_read=0, a_data driven with latched wb_data, b_read=1, b=0; at the edge closing WRITE: pending[wb_reg] cleared, -> HOLD if ret_hold else IDLE.
REQ-014 WRITE SHALL last exactly one cycle; out_op_*, out_dst* SHALL remain stable throughout HOLD and an interleaved WRITE.
REQ-015 In IDLE and HOLD: a_read=b_read=1, a=b=0, block does not drive either bus.
REQ-016 Writeback to a register with pending=0 SHALL still write; clearing an already-clear bit is harmless.
REQ-017 The block SHALL never drive a bus while the corresponding read is 1.

Reset
REQ-018 While reset_n=0: state IDLE, ret_hold 0, pending 8'h00, out_valid 0, out_op_a/b 16'h0000, out_dst 0, out_dst_we 0, a=b=0, a_read=b_read=1, buses Z.
REQ-019 Reset mid-READ or mid-WRITE SHALL abort the operation; a WRITE aborted before its closing edge SHALL NOT be counted as written.

Configuration
REQ-020 With FETCH_ZERO_R0_EN defined: register 0 reads as 16'h0000 (out_op forced, bus still tri-stated), writebacks to reg 0 are accepted and acknowledged but skip WRITE (a_read stays 1), pending[0] is never set.
REQ-021 Without FETCH_ZERO_R0_EN: register 0 is an ordinary register.

Verification
REQ-022 Write r0=ABCD, r1=1234 via wb, then fetch src_a=1, src_b=0 -> out_op_a=1234, out_op_b=ABCD, out_valid 2 edges after accept.
REQ-023 Fetch dst=3 we=1, consume; next fetch src_a=3 -> in_ready=0 until wb reg 3 (data 00FF) completes WRITE, then out_op_a=00FF.
REQ-024 wb_valid and in_valid asserted together in IDLE -> WRITE first, instruction accepted the cycle after.
REQ-025 Hold out_ready=0 in HOLD, issue wb reg 5=BEEF -> WRITE then HOLD, out_op unchanged, bus a shows BEEF with a_read=0 for exactly one cycle.
REQ-026 Assert reset_n=0 during READ -> out_valid=0, pending=00, a_read=b_read=1 immediately.
REQ-027 With FETCH_ZERO_R0_EN: wb reg 0=FFFF then fetch src_a=0 -> out_op_a=0000, no a_read=0 cycle seen.
